// File: rtl/is_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : is_uart_pkg
//  Purpose  : Shared UART types and helpers for the receiver and a future
//             transmitter.
//    uart_rx_state_t : receiver FSM state encoding
//    calc_tick_div   : system clocks per oversampling tick
//  Revision : 1.0 - initial release
// ============================================================================
package is_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

  // System clocks per oversampling tick, truncated. Evaluated in 64 bits so
  // large clock frequencies cannot overflow the intermediate product.
  function automatic int calc_tick_div(input int fast_clk_mhz,
                                       input int baud_rate,
                                       input int oversample);
    longint num;
    longint den;
    num = longint'(fast_clk_mhz) * 64'd1_000_000;
    den = longint'(baud_rate) * longint'(oversample);
    return int'(num / den);
  endfunction

endpackage : is_uart_pkg
`default_nettype wire

// File: rtl/is_uart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module   : is_uart_baud_tick
//  Purpose  : Reloadable down-counter producing a one-cycle tick enable every
//             DIV system clocks.
//    clk_i  : system clock
//    rst_i  : synchronous active-low reset (counter to 0)
//    clr_i  : reload DIV-1 without producing a tick
//    tick_o : one-cycle enable when the counter reaches 0
//  Revision : 1.0 - initial release
// ============================================================================
module is_uart_baud_tick #(
  parameter int DIV = 54
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int                c_cnt_w  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(DIV - 1);
  localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (clr_i || (r_cnt == '0)) begin
      r_cnt <= c_reload;
    end else begin
      r_cnt <= r_cnt - c_one;
    end
  end

  // A clear suppresses the tick so the caller restarts phase from zero.
  assign tick_o = (r_cnt == '0) && !clr_i;

endmodule : is_uart_baud_tick
`default_nettype wire

// File: rtl/is_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : is_uart_rx
//  Purpose  : Oversampling UART receiver (8N1 default, LSB first) running in
//             the system clock domain, with valid/ready output handshake.
//    clk_i       : system clock
//    rst_i       : synchronous active-low reset
//    rx_i        : asynchronous serial line, idle high
//    data_o      : received word, LSB = first data bit
//    valid_o     : data_o holds an unread word
//    ready_i     : consumer accepts data_o when valid_o && ready_i
//    frame_err_o : one-cycle pulse, stop bit sampled low
//    overrun_o   : one-cycle pulse, word completed while valid_o still high
//  Revision : 1.0 - initial release
// ============================================================================
module is_uart_rx
  import is_uart_pkg::*;
#(
  parameter int FAST_CLK_MHZ = 100,
  parameter int BAUD_RATE    = 115200,
  parameter int OVERSAMPLE   = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o
);

  localparam int c_tick_div = calc_tick_div(FAST_CLK_MHZ, BAUD_RATE, OVERSAMPLE);
  localparam int c_tcnt_w   = $clog2(OVERSAMPLE);
  localparam int c_bcnt_w   = $clog2(DATA_BITS + 1);

  localparam logic [c_tcnt_w-1:0] c_half_last = c_tcnt_w'(OVERSAMPLE / 2 - 1);
  localparam logic [c_tcnt_w-1:0] c_os_last   = c_tcnt_w'(OVERSAMPLE - 1);
  localparam logic [c_tcnt_w-1:0] c_tcnt_one  = c_tcnt_w'(1);
  localparam logic [c_bcnt_w-1:0] c_bits_last = c_bcnt_w'(DATA_BITS - 1);
  localparam logic [c_bcnt_w-1:0] c_bcnt_one  = c_bcnt_w'(1);

  generate
    if (c_tick_div < 2) begin : g_div_check
      $error("is_uart_rx: clock too slow for baud rate, tick divider below 2");
    end
    if ((OVERSAMPLE < 8) || ((OVERSAMPLE % 2) != 0)) begin : g_os_check
      $error("is_uart_rx: OVERSAMPLE must be even and at least 8");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bits_check
      $error("is_uart_rx: DATA_BITS must be in 5..9");
    end
  endgenerate

  uart_rx_state_t       r_state,  w_state_nxt;
  logic [c_tcnt_w-1:0]  r_tcnt,   w_tcnt_nxt;
  logic [c_bcnt_w-1:0]  r_bcnt,   w_bcnt_nxt;
  logic [DATA_BITS-1:0] r_shift,  w_shift_nxt;
  logic                 r_sync1, r_sync2, r_rx_prev;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid, r_ferr, r_ovr;
  logic                 w_tick, w_clr, w_deliver, w_ferr;

  is_uart_baud_tick #(
    .DIV (c_tick_div)
  ) u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (w_clr),
    .tick_o (w_tick)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_nxt  = r_tcnt;
    w_bcnt_nxt  = r_bcnt;
    w_shift_nxt = r_shift;
    w_clr       = 1'b0;
    w_deliver   = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      IDLE: begin
        // Only a high-to-low transition starts a frame, so a line stuck low
        // after a framing error cannot retrigger.
        if (!r_sync2 && r_rx_prev) begin
          w_clr       = 1'b1;
          w_tcnt_nxt  = '0;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_tick) begin
          if (r_tcnt == c_half_last) begin
            if (!r_sync2) begin
              w_tcnt_nxt  = '0;
              w_bcnt_nxt  = '0;
              w_state_nxt = DATA;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_tcnt_nxt = r_tcnt + c_tcnt_one;
          end
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_tcnt == c_os_last) begin
            w_tcnt_nxt  = '0;
            w_shift_nxt = {r_sync2, r_shift[DATA_BITS-1:1]};
            if (r_bcnt == c_bits_last) begin
              w_state_nxt = STOP;
            end else begin
              w_bcnt_nxt = r_bcnt + c_bcnt_one;
            end
          end else begin
            w_tcnt_nxt = r_tcnt + c_tcnt_one;
          end
        end
      end
      STOP: begin
        // Returning to IDLE at mid stop bit leaves half a bit of margin for
        // the next start edge of a back-to-back frame.
        if (w_tick) begin
          if (r_tcnt == c_os_last) begin
            w_tcnt_nxt  = '0;
            w_deliver   = r_sync2;
            w_ferr      = !r_sync2;
            w_state_nxt = IDLE;
          end else begin
            w_tcnt_nxt = r_tcnt + c_tcnt_one;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
      r_tcnt    <= '0;
      r_bcnt    <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_sync1   <= rx_i;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
      r_tcnt    <= w_tcnt_nxt;
      r_bcnt    <= w_bcnt_nxt;
      r_shift   <= w_shift_nxt;
      r_ferr    <= w_ferr;
      r_ovr     <= w_deliver && r_valid && !ready_i;
      // A word completing in the same cycle as an acceptance replaces the
      // accepted word, keeping valid high without a gap.
      if (w_deliver && (!r_valid || ready_i)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_o      = r_data;
  assign valid_o     = r_valid;
  assign frame_err_o = r_ferr;
  assign overrun_o   = r_ovr;

endmodule : is_uart_rx
`default_nettype wire

// File: tb/tb_is_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_is_uart_rx
//  Purpose  : Directed self-checking bench for is_uart_rx at default
//             parameters (100 MHz, 115200 baud, 16x, 8 data bits).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_is_uart_rx;

  localparam int c_bit_cyc = 864;   // 16 ticks * 54 clocks

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       rx_i = 1'b1;
  logic       ready_i = 1'b0;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       overrun_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Free-running monitor counters, sampled on the falling edge.
  int         cyc = 0;
  int         n_rise = 0;
  int         n_fall = 0;
  int         n_vcyc = 0;
  int         n_acc = 0;
  int         n_ferr = 0;
  int         n_ovr = 0;
  int         rise_cyc = 0;
  logic [7:0] last_acc = 8'h00;
  logic       mon_prev_valid = 1'b0;

  int         fall_cyc = 0;
  logic [7:0] snap_data;
  logic       snap_valid, snap_ferr, snap_ovr;

  is_uart_rx dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_o && !mon_prev_valid) begin
      n_rise++;
      rise_cyc = cyc;
    end
    if (!valid_o && mon_prev_valid) n_fall++;
    if (valid_o) n_vcyc++;
    if (valid_o && ready_i) begin
      n_acc++;
      last_acc = data_o;
    end
    if (frame_err_o) n_ferr++;
    if (overrun_o) n_ovr++;
    mon_prev_valid = valid_o;
  end

  // One frame: start, 8 data bits LSB first, stop of the given level.
  // rst_bit >= 0 pulses reset in the middle of that data bit and captures
  // the outputs while reset is held.
  task automatic send_frame(input logic [7:0] d, input logic stop_val,
                            input int bit_cyc, input int rst_bit);
    @(posedge clk); #1;
    rx_i = 1'b0;
    fall_cyc = cyc;
    repeat (bit_cyc) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      if (i == rst_bit) begin
        repeat (bit_cyc / 4) @(posedge clk);
        #1 rst_i = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        snap_data  = data_o;
        snap_valid = valid_o;
        snap_ferr  = frame_err_o;
        snap_ovr   = overrun_o;
        @(posedge clk); #1 rst_i = 1'b1;
        repeat (bit_cyc - bit_cyc / 4 - 5) @(posedge clk);
        #1;
      end else begin
        repeat (bit_cyc) @(posedge clk);
        #1;
      end
    end
    rx_i = stop_val;
    repeat (bit_cyc) @(posedge clk);
    #1 rx_i = 1'b1;
  endtask

  task automatic test_reset();
    int b_rise;
    rst_i = 1'b0; rx_i = 1'b1; ready_i = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %0h expected 00", data_o); end
    n_checks++;
    if ({valid_o, frame_err_o, overrun_o} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {valid_o, frame_err_o, overrun_o});
    end
    b_rise = n_rise;
    @(posedge clk); #1 rst_i = 1'b1;
    repeat (20) @(posedge clk);
    n_checks++;
    if (n_rise - b_rise !== 0) begin n_fail++; $display("FAIL idle_after_reset: got %0d valid rises expected 0", n_rise - b_rise); end
  endtask

  task automatic test_basic();
    int b_rise, b_vcyc, b_acc, b_ferr, b_ovr, lat;
    @(posedge clk); #1 ready_i = 1'b1;
    b_rise = n_rise; b_vcyc = n_vcyc; b_acc = n_acc; b_ferr = n_ferr; b_ovr = n_ovr;
    send_frame(8'hA5, 1'b1, c_bit_cyc, -1);
    repeat (20) @(posedge clk);
    n_checks++;
    if (last_acc !== 8'hA5 || n_acc - b_acc !== 1) begin
      n_fail++; $display("FAIL basic_data: got %0h (%0d accepts) expected a5 (1)", last_acc, n_acc - b_acc);
    end
    n_checks++;
    if (n_vcyc - b_vcyc !== 1) begin n_fail++; $display("FAIL basic_valid_width: got %0d cycles expected 1", n_vcyc - b_vcyc); end
    lat = rise_cyc - fall_cyc;
    n_checks++;
    if (n_rise - b_rise !== 1 || lat < 8205 || lat > 8211) begin
      n_fail++; $display("FAIL basic_latency: got %0d cycles expected 8205..8211", lat);
    end
    n_checks++;
    if (n_ferr - b_ferr !== 0 || n_ovr - b_ovr !== 0) begin
      n_fail++; $display("FAIL basic_no_errors: got ferr=%0d ovr=%0d expected 0 0", n_ferr - b_ferr, n_ovr - b_ovr);
    end
  endtask

  task automatic test_back_to_back();
    int b_rise, b_fall, b_acc, b_ovr;
    @(posedge clk); #1 ready_i = 1'b0;
    b_rise = n_rise; b_fall = n_fall; b_acc = n_acc; b_ovr = n_ovr;
    send_frame(8'h3C, 1'b1, c_bit_cyc, -1);
    send_frame(8'hC3, 1'b1, c_bit_cyc, -1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (valid_o !== 1'b1 || data_o !== 8'h3C) begin
      n_fail++; $display("FAIL b2b_hold: got valid=%b data=%0h expected 1 3c", valid_o, data_o);
    end
    n_checks++;
    if (n_rise - b_rise !== 1 || n_fall - b_fall !== 0) begin
      n_fail++; $display("FAIL b2b_valid_steady: got rises=%0d falls=%0d expected 1 0", n_rise - b_rise, n_fall - b_fall);
    end
    n_checks++;
    if (n_ovr - b_ovr !== 1) begin n_fail++; $display("FAIL b2b_overrun: got %0d pulse cycles expected 1", n_ovr - b_ovr); end
    @(posedge clk); #1 ready_i = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_release: got valid=%b expected 0", valid_o); end
    n_checks++;
    if (n_acc - b_acc !== 1 || last_acc !== 8'h3C) begin
      n_fail++; $display("FAIL b2b_accept: got %0h (%0d accepts) expected 3c (1)", last_acc, n_acc - b_acc);
    end
  endtask

  task automatic test_frame_error();
    int b_rise, b_acc, b_ferr;
    b_rise = n_rise; b_acc = n_acc; b_ferr = n_ferr;
    send_frame(8'h55, 1'b0, c_bit_cyc, -1);
    repeat (100) @(posedge clk);
    n_checks++;
    if (n_ferr - b_ferr !== 1) begin n_fail++; $display("FAIL ferr_pulse: got %0d pulse cycles expected 1", n_ferr - b_ferr); end
    n_checks++;
    if (n_rise - b_rise !== 0) begin n_fail++; $display("FAIL ferr_no_valid: got %0d rises expected 0", n_rise - b_rise); end
    send_frame(8'h0F, 1'b1, c_bit_cyc, -1);
    repeat (20) @(posedge clk);
    n_checks++;
    if (last_acc !== 8'h0F || n_acc - b_acc !== 1 || n_ferr - b_ferr !== 1) begin
      n_fail++; $display("FAIL ferr_recover: got %0h (%0d accepts) expected 0f (1)", last_acc, n_acc - b_acc);
    end
  endtask

  task automatic test_glitch();
    int b_rise, b_acc, b_ferr, b_ovr;
    b_rise = n_rise; b_acc = n_acc; b_ferr = n_ferr; b_ovr = n_ovr;
    @(posedge clk); #1 rx_i = 1'b0;
    repeat (20) @(posedge clk);
    #1 rx_i = 1'b1;
    repeat (1000) @(posedge clk);
    n_checks++;
    if (n_rise - b_rise !== 0 || n_ferr - b_ferr !== 0 || n_ovr - b_ovr !== 0) begin
      n_fail++; $display("FAIL glitch_ignored: got rises=%0d ferr=%0d ovr=%0d expected 0 0 0",
                         n_rise - b_rise, n_ferr - b_ferr, n_ovr - b_ovr);
    end
    send_frame(8'hFF, 1'b1, c_bit_cyc, -1);
    repeat (20) @(posedge clk);
    n_checks++;
    if (last_acc !== 8'hFF || n_acc - b_acc !== 1) begin
      n_fail++; $display("FAIL glitch_recover: got %0h (%0d accepts) expected ff (1)", last_acc, n_acc - b_acc);
    end
  endtask

  task automatic test_reset_midframe();
    int b_rise, b_acc, b_ferr, b_ovr;
    b_rise = n_rise; b_acc = n_acc; b_ferr = n_ferr; b_ovr = n_ovr;
    // Reset lands in data bit 7, which is high, so the rest of the frame
    // looks like an idle line.
    send_frame(8'h81, 1'b1, c_bit_cyc, 7);
    repeat (200) @(posedge clk);
    n_checks++;
    if (snap_data !== 8'h00 || {snap_valid, snap_ferr, snap_ovr} !== 3'b000) begin
      n_fail++; $display("FAIL midreset_outputs: got data=%0h flags=%b expected 00 000",
                         snap_data, {snap_valid, snap_ferr, snap_ovr});
    end
    n_checks++;
    if (n_rise - b_rise !== 0 || n_ferr - b_ferr !== 0 || n_ovr - b_ovr !== 0) begin
      n_fail++; $display("FAIL midreset_silent: got rises=%0d ferr=%0d ovr=%0d expected 0 0 0",
                         n_rise - b_rise, n_ferr - b_ferr, n_ovr - b_ovr);
    end
    send_frame(8'h7E, 1'b1, c_bit_cyc, -1);
    repeat (20) @(posedge clk);
    n_checks++;
    if (last_acc !== 8'h7E || n_acc - b_acc !== 1) begin
      n_fail++; $display("FAIL midreset_recover: got %0h (%0d accepts) expected 7e (1)", last_acc, n_acc - b_acc);
    end
  endtask

  task automatic test_baud_tolerance();
    int b_acc, b_ferr;
    b_acc = n_acc; b_ferr = n_ferr;
    send_frame(8'h96, 1'b1, 881, -1);   // 2% slow
    repeat (50) @(posedge clk);
    n_checks++;
    if (last_acc !== 8'h96 || n_acc - b_acc !== 1 || n_ferr - b_ferr !== 0) begin
      n_fail++; $display("FAIL baud_slow: got %0h accepts=%0d ferr=%0d expected 96 1 0",
                         last_acc, n_acc - b_acc, n_ferr - b_ferr);
    end
    b_acc = n_acc;
    send_frame(8'h96, 1'b1, 847, -1);   // 2% fast
    repeat (50) @(posedge clk);
    n_checks++;
    if (last_acc !== 8'h96 || n_acc - b_acc !== 1 || n_ferr - b_ferr !== 0) begin
      n_fail++; $display("FAIL baud_fast: got %0h accepts=%0d ferr=%0d expected 96 1 0",
                         last_acc, n_acc - b_acc, n_ferr - b_ferr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_reset_midframe();
    test_baud_tolerance();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_is_uart_rx
`default_nettype wire
